morph_seq_ctrl: RTL

//  Sequencer for the two cascaded binary morphology stages (erode/dilate) after binarisation.

---
 rtl/morph_pkg.sv | 44 ++++
 rtl/morph_seq_ctrl_if.sv | 24 ++
 rtl/sync_delay.sv | 30 +++
 rtl/morph_seq_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/morph_pkg.sv
// Shared encodings for the morphology sequencer: processing modes, stage op
// codes, control FSM states and the bundled sync triple.
package morph_pkg;

    typedef enum logic [2:0] {
        MODE_BYP   = 3'd0,
        MODE_ERO   = 3'd1,
        MODE_DIL   = 3'd2,
        MODE_OPEN  = 3'd3,
        MODE_CLOSE = 3'd4
    } mode_e;

    localparam logic OP_ERODE  = 1'b0;
    localparam logic OP_DILATE = 1'b1;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_e;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } sync_t;

    // Codes 5..7 are reserved and must never reach the datapath.
    function automatic logic mode_valid(input logic [2:0] m);
        return m <= 3'(MODE_CLOSE);
    endfunction

    // Returns {stage-1 op, stage-2 op} for a mode.
    function automatic logic [1:0] mode_ops(input mode_e m);
        case (m)
            MODE_ERO:   return {OP_ERODE,  OP_ERODE};
            MODE_DIL:   return {OP_DILATE, OP_ERODE};
            MODE_OPEN:  return {OP_ERODE,  OP_DILATE};
            MODE_CLOSE: return {OP_DILATE, OP_ERODE};
            default:    return {OP_ERODE,  OP_ERODE};
        endcase
    endfunction

endpackage

// File: rtl/morph_seq_ctrl_if.sv
// Host configuration port of the morphology sequencer: mode write strobe in,
// busy/error status back to the host.
interface morph_seq_ctrl_if;

    logic [2:0] cfg_mode;
    logic       cfg_wr;
    logic       cfg_busy;
    logic       cfg_err;

    modport master (
        output cfg_mode,
        output cfg_wr,
        input  cfg_busy,
        input  cfg_err
    );

    modport slave (
        input  cfg_mode,
        input  cfg_wr,
        output cfg_busy,
        output cfg_err
    );

endinterface

// File: rtl/sync_delay.sv
// Fixed-depth shift-register delay line; every tap clears on reset so the
// delayed stream restarts from an all-zero state.
module sync_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [DEPTH-1:0][WIDTH-1:0] pipe_q;

    // NOTE: every tap is reset on purpose -- this is a short pipeline, not a RAM,
    // and a stale tap would leak old pixels/sync onto the outputs after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/morph_seq_ctrl.sv
// Sequencer for two cascaded binary morphology stages: frame-aligned mode
// switching, stage op select and a constant-latency output mux.
// Build option: define MORPH_STATS_EN to include the frame counter and geometry checker.
module morph_seq_ctrl
    import morph_pkg::*;
#(
    parameter logic [11:0] H_DISP    = 12'd480,
    parameter logic [11:0] V_DISP    = 12'd272,
    parameter int          STAGE_LAT = 3,
    parameter logic        VS_POL    = 1'b1,
    parameter logic [2:0]  DEF_MODE  = 3'd0
) (
    input  logic              clk,
    input  logic              rst_n,
    morph_seq_ctrl_if.slave   cfg,
    input  logic              in_de,
    input  logic              in_hsync,
    input  logic              in_vsync,
    input  logic [7:0]        in_data,
    output logic              s1_op,
    output logic              s2_op,
    input  logic [7:0]        s1_data,
    input  logic [7:0]        s2_data,
    output logic              out_de,
    output logic              out_hsync,
    output logic              out_vsync,
    output logic [7:0]        out_data,
    output logic [15:0]       frame_cnt,
    output logic              geom_err
);

    localparam int OUT_LAT = 2 * STAGE_LAT;

    state_e state_q, state_d;
    mode_e  pend_q, pend_d;
    logic   pend_vld_q, pend_vld_d;
    mode_e  in_mode_q, in_mode_d;
    mode_e  out_mode_q;
    logic   err_q;
    logic   in_vs_q, out_vs_q;
    logic   s1_op_q, s2_op_q;

    logic   in_fs, out_fs;
    logic   wr_ok, wr_bad;
    sync_t  in_sync, tap_sync;
    logic [7:0] byp_tap, s1_tap, sel_data;

    // Frame start is the transition into the active vsync level.
    assign in_fs  = (in_vsync == VS_POL) && (in_vs_q != VS_POL);
    assign wr_ok  = cfg.cfg_wr &&  mode_valid(cfg.cfg_mode);
    assign wr_bad = cfg.cfg_wr && !mode_valid(cfg.cfg_mode);

    // NOTE: all outputs of this block get a default first, so no path through
    // the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        in_mode_d  = in_mode_q;

        // The edge consumes the request that was pending before this clock;
        // a write in the same clock becomes the request for the next frame.
        if (in_fs && pend_vld_q) begin
            in_mode_d = pend_q;
        end
        if (wr_ok) begin
            pend_d     = mode_e'(cfg.cfg_mode);
            pend_vld_d = 1'b1;
        end else if (in_fs) begin
            pend_vld_d = 1'b0;
        end

        case (state_q)
            ST_WAIT: if (in_fs) state_d = wr_ok ? ST_PEND : ST_RUN;
            ST_RUN:  if (wr_ok) state_d = ST_PEND;
            ST_PEND: if (in_fs && !wr_ok) state_d = ST_RUN;
            default: state_d = ST_WAIT;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_WAIT;
            pend_q     <= MODE_BYP;
            pend_vld_q <= 1'b0;
            in_mode_q  <= mode_e'(DEF_MODE);
            out_mode_q <= mode_e'(DEF_MODE);
            err_q      <= 1'b0;
            in_vs_q    <= VS_POL;
            out_vs_q   <= VS_POL;
            s1_op_q    <= OP_ERODE;
            s2_op_q    <= OP_ERODE;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            in_mode_q  <= in_mode_d;
            err_q      <= wr_bad;
            in_vs_q    <= in_vsync;
            out_vs_q   <= tap_sync.vs;
            {s1_op_q, s2_op_q} <= mode_ops(in_mode_q);
            if (out_fs) begin
                out_mode_q <= in_mode_q;
            end
        end
    end

    assign cfg.cfg_busy = pend_vld_q;
    assign cfg.cfg_err  = err_q;
    assign s1_op        = s1_op_q;
    assign s2_op        = s2_op_q;

    assign in_sync = {in_de, in_hsync, in_vsync};

    sync_delay #(.WIDTH(3), .DEPTH(OUT_LAT)) u_sync_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (in_sync),
        .q_o   (tap_sync)
    );

    sync_delay #(.WIDTH(8), .DEPTH(OUT_LAT)) u_byp_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (in_data),
        .q_o   (byp_tap)
    );

    sync_delay #(.WIDTH(8), .DEPTH(STAGE_LAT)) u_s1_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (s1_data),
        .q_o   (s1_tap)
    );

    assign out_fs = (tap_sync.vs == VS_POL) && (out_vs_q != VS_POL);

    // Each path is padded to 2*STAGE_LAT, so switching modes never shifts timing.
    always_comb begin
        sel_data = '0;
        case (out_mode_q)
            MODE_BYP:              sel_data = byp_tap;
            MODE_ERO,  MODE_DIL:   sel_data = s1_tap;
            MODE_OPEN, MODE_CLOSE: sel_data = s2_data;
            default:               sel_data = '0;
        endcase
    end

    assign out_de    = tap_sync.de && (state_q != ST_WAIT);
    assign out_hsync = tap_sync.hs;
    assign out_vsync = tap_sync.vs;
    assign out_data  = out_de ? sel_data : 8'h00;

`ifdef MORPH_STATS_EN
    logic        de_prev_q;
    logic [11:0] run_len_q;
    logic [11:0] run_cnt_q;
    logic        fs_seen_q;
    logic [15:0] frame_cnt_q;
    logic        geom_err_q;
    logic        run_start, run_end;

    assign run_start = out_de && !de_prev_q;
    assign run_end   = de_prev_q && !out_de;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_prev_q   <= 1'b0;
            run_len_q   <= '0;
            run_cnt_q   <= '0;
            fs_seen_q   <= 1'b0;
            frame_cnt_q <= '0;
            geom_err_q  <= 1'b0;
        end else begin
            de_prev_q <= out_de;

            // Saturate so an overlong run cannot wrap back to a legal length.
            if (run_start) begin
                run_len_q <= 12'd1;
            end else if (out_de && run_len_q != '1) begin
                run_len_q <= run_len_q + 12'd1;
            end
            if (run_end && run_len_q != H_DISP) begin
                geom_err_q <= 1'b1;
            end

            // The first edge after reset closes no complete frame, so it is not checked.
            if (out_fs) begin
                run_cnt_q <= {11'd0, run_start};
                fs_seen_q <= 1'b1;
                if (fs_seen_q) begin
                    frame_cnt_q <= frame_cnt_q + 16'd1;
                    if (run_cnt_q != V_DISP) begin
                        geom_err_q <= 1'b1;
                    end
                end
            end else if (run_start && run_cnt_q != '1) begin
                run_cnt_q <= run_cnt_q + 12'd1;
            end
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign geom_err  = geom_err_q;
`else
    logic unused_geom;
    assign unused_geom = ^{H_DISP, V_DISP};
    assign frame_cnt   = '0;
    assign geom_err    = 1'b0;
`endif

endmodule
